// File: rtl/vc_fifo.sv
// vc_fifo: VC_NUM independent flit queues behind one push and one pop port.
// Define VC_FIFO_BYPASS_EN to let a push into an empty VC be popped in the same cycle.
module vc_fifo #(
  parameter int FIFO_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int VC_NUM     = 4,
  parameter int AFULL_TH   = 3,
  localparam int VC_W      = $clog2(VC_NUM),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [VC_W-1:0]         push_vc,
  input  logic [FIFO_WIDTH-1:0]   din,
  input  logic                    pop,
  input  logic [VC_W-1:0]         pop_vc,
  output logic [FIFO_WIDTH-1:0]   dout,
  output logic [VC_NUM*CNT_W-1:0] fifo_cnt,
  output logic [VC_NUM-1:0]       nempty,
  output logic [VC_NUM-1:0]       full,
  output logic [VC_NUM-1:0]       afull,
  output logic                    crd_rtn,
  output logic [VC_W-1:0]         crd_rtn_vc,
  output logic                    ovf_err,
  output logic                    udf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_r [VC_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r [VC_NUM];
  logic [PTR_W-1:0]      rd_ptr_r [VC_NUM];
  logic [CNT_W-1:0]      cnt_r [VC_NUM];
  logic [CNT_W-1:0]      cnt_nxt_s [VC_NUM];
  logic [VC_NUM-1:0]     nempty_r, full_r, afull_r;
  logic                  crd_rtn_r, ovf_err_r, udf_err_r;
  logic [VC_W-1:0]       crd_rtn_vc_r;
  logic                  acc_push_s, acc_pop_s, byp_s, store_s, drain_s;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Acceptance of this cycle's push and pop; a bypassed flit is never stored.
  always_comb begin
    byp_s     = 1'b0;
    acc_pop_s = pop & nempty_r[pop_vc];
`ifdef VC_FIFO_BYPASS_EN
    byp_s     = push & pop & (push_vc == pop_vc) & ~nempty_r[pop_vc];
    acc_pop_s = acc_pop_s | byp_s;
`else
    byp_s     = 1'b0;
`endif
    acc_push_s = push & (~full_r[push_vc] | (acc_pop_s & (pop_vc == push_vc)));
    store_s    = acc_push_s & ~byp_s;
    drain_s    = acc_pop_s & ~byp_s;
  end

  // Head flit of the selected VC, or the incoming flit when bypassing.
  always_comb begin
    if (byp_s) begin
      dout = din;
    end else begin
      dout = mem_r[pop_vc][rd_ptr_r[pop_vc]];
    end
  end

  // Next-cycle occupancy per VC; the flags are loaded from it.
  always_comb begin
    for (int k = 0; k < VC_NUM; k++) begin
      cnt_nxt_s[k] = cnt_r[k]
                   + CNT_W'(store_s & (push_vc == VC_W'(k)))
                   - CNT_W'(drain_s & (pop_vc == VC_W'(k)));
    end
  end

  // Flatten per-VC counts onto the output bus.
  always_comb begin
    for (int k = 0; k < VC_NUM; k++) begin
      fifo_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
  end

  // Flit storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (store_s) begin
      mem_r[push_vc][wr_ptr_r[push_vc]] <= din;
    end
  end

  // Pointers, counts, status flags, credit return and sticky errors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < VC_NUM; k++) begin
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        cnt_r[k]    <= {CNT_W{1'b0}};
      end
      nempty_r     <= {VC_NUM{1'b0}};
      full_r       <= {VC_NUM{1'b0}};
      afull_r      <= {VC_NUM{1'b0}};
      crd_rtn_r    <= 1'b0;
      crd_rtn_vc_r <= {VC_W{1'b0}};
      ovf_err_r    <= 1'b0;
      udf_err_r    <= 1'b0;
    end else begin
      for (int k = 0; k < VC_NUM; k++) begin
        cnt_r[k]    <= cnt_nxt_s[k];
        nempty_r[k] <= (cnt_nxt_s[k] != {CNT_W{1'b0}});
        full_r[k]   <= (cnt_nxt_s[k] == CNT_W'(FIFO_DEPTH));
        afull_r[k]  <= (cnt_nxt_s[k] >= CNT_W'(AFULL_TH));
      end
      if (store_s) begin
        wr_ptr_r[push_vc] <= next_ptr(wr_ptr_r[push_vc]);
      end
      if (drain_s) begin
        rd_ptr_r[pop_vc] <= next_ptr(rd_ptr_r[pop_vc]);
      end
      crd_rtn_r <= acc_pop_s;
      if (acc_pop_s) begin
        crd_rtn_vc_r <= pop_vc;
      end
      if (push & ~acc_push_s) begin
        ovf_err_r <= 1'b1;
      end
      if (pop & ~acc_pop_s) begin
        udf_err_r <= 1'b1;
      end
    end
  end

  assign nempty     = nempty_r;
  assign full       = full_r;
  assign afull      = afull_r;
  assign crd_rtn    = crd_rtn_r;
  assign crd_rtn_vc = crd_rtn_vc_r;
  assign ovf_err    = ovf_err_r;
  assign udf_err    = udf_err_r;

endmodule
